// File: rtl/riot_port_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riot_port_timer                                              |
// | Description : Parametrised RRIOT-style I/O and timer core. NUM_PORTS ports |
// |               with per-bit direction registers, an 8-bit interval timer   |
// |               with /1, /8, /64, /1024 prescale and fast post-underflow    |
// |               countdown, and an edge detector on one bit of port 0.       |
// |               Optional macro RIOT_PB7_IRQ_EN turns the top bit of port 1  |
// |               into an open-drain active-low IRQ pin.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module riot_port_timer #(
   parameter int NUM_PORTS  = 2,
   parameter int PORT_WIDTH = 8,
   parameter int ED_BIT     = 7
) (
   input  logic                            phi2_i,
   input  logic                            rst_i,
   input  logic                            cs_i,
   input  logic                            we_n_i,
   input  logic [4:0]                      addr_i,
   input  logic [7:0]                      di_i,
   output logic [7:0]                      do_o,
   output logic                            oe_o,
   input  logic [NUM_PORTS*PORT_WIDTH-1:0] pi_i,
   output logic [NUM_PORTS*PORT_WIDTH-1:0] po_o,
   output logic [NUM_PORTS*PORT_WIDTH-1:0] ddr_o,
   output logic                            irq_o
);

   localparam int PW_ALL = NUM_PORTS * PORT_WIDTH;

   // Prescaler reload value (divisor - 1) for each prescale select code.
   function automatic logic [9:0] presc_reload(input logic [1:0] sel);
      logic [9:0] val;
      case (sel)
         2'b00:   val = 10'd0;
         2'b01:   val = 10'd7;
         2'b10:   val = 10'd63;
         default: val = 10'd1023;
      endcase
      return val;
   endfunction

   logic [PW_ALL-1:0]     po_q, po_d, ddr_q, ddr_d;
   logic [PW_ALL-1:0]     po_eff, ddr_eff, pin_read;
   logic [7:0]            timer_q, timer_d;
   logic [9:0]            presc_q, presc_d;
   logic [1:0]            sel_q, sel_d;
   logic                  fast_q, fast_d;
   logic                  tflag_q, tflag_d, tie_q, tie_d;
   logic                  eflag_q, eflag_d, eie_q, eie_d, epol_q, epol_d;
   logic                  prev_q;
   logic                  irq_q, irq_d;
   logic                  uf;
   logic [PORT_WIDTH-1:0] port_val;

   logic       rd_en, wr_en, ctl_sel, ed_pin, ed_hit;
   logic [2:0] port_idx;

   assign rd_en    = cs_i & we_n_i;
   assign wr_en    = cs_i & ~we_n_i;
   assign ctl_sel  = addr_i[4];
   assign port_idx = addr_i[3:1];
   assign ed_pin   = pi_i[ED_BIT];
   assign ed_hit   = epol_q ? (~prev_q & ed_pin) : (prev_q & ~ed_pin);
   assign oe_o     = rd_en;
   assign irq_o    = irq_q;

`ifdef RIOT_PB7_IRQ_EN
   generate
      if (NUM_PORTS >= 2) begin : g_pb7
         // Top bit of port 1 becomes an open-drain IRQ: data forced low, direction follows irq.
         always_comb begin
            po_eff                     = po_q;
            ddr_eff                    = ddr_q;
            po_eff[2*PORT_WIDTH-1]     = 1'b0;
            ddr_eff[2*PORT_WIDTH-1]    = irq_q;
         end
      end else begin : g_no_pb7
         assign po_eff  = po_q;
         assign ddr_eff = ddr_q;
      end
   endgenerate
`else
   assign po_eff  = po_q;
   assign ddr_eff = ddr_q;
`endif

   assign po_o     = po_eff;
   assign ddr_o    = ddr_eff;
   assign pin_read = (ddr_eff & po_eff) | (~ddr_eff & pi_i);

   // Read data mux: timer/flags in control space, port data or direction in port space.
   always_comb begin
      do_o     = 8'h00;
      port_val = '0;
      if (cs_i) begin
         if (ctl_sel) begin
            do_o = addr_i[0] ? {tflag_q, eflag_q, 6'b000000} : timer_q;
         end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               if (32'(port_idx) == k) begin
                  port_val = addr_i[0] ? ddr_eff[k*PORT_WIDTH +: PORT_WIDTH]
                                       : pin_read[k*PORT_WIDTH +: PORT_WIDTH];
               end
            end
            do_o = 8'(port_val);
         end
      end
   end

   // Next-state logic: counting first, then read-clears, then events that set flags,
   // then timer load so a load overrides a coincident underflow.
   always_comb begin
      po_d    = po_q;
      ddr_d   = ddr_q;
      timer_d = timer_q;
      presc_d = presc_q;
      sel_d   = sel_q;
      fast_d  = fast_q;
      tflag_d = tflag_q;
      tie_d   = tie_q;
      eflag_d = eflag_q;
      eie_d   = eie_q;
      epol_d  = epol_q;
      uf      = 1'b0;

      if (fast_q || (presc_q == 10'd0)) begin
         timer_d = timer_q - 8'd1;
         uf      = (timer_q == 8'h00);
         if (!fast_q) begin
            presc_d = presc_reload(sel_q);
         end
      end else begin
         presc_d = presc_q - 10'd1;
      end

      if (rd_en && ctl_sel && !addr_i[0]) begin
         tflag_d = 1'b0;
         tie_d   = addr_i[3];
      end
      if (uf) begin
         tflag_d = 1'b1;
         fast_d  = 1'b1;
      end
      if (wr_en && ctl_sel && addr_i[2]) begin
         timer_d = di_i;
         sel_d   = addr_i[1:0];
         presc_d = presc_reload(addr_i[1:0]);
         tie_d   = addr_i[3];
         tflag_d = 1'b0;
         fast_d  = 1'b0;
      end

      if (wr_en && ctl_sel && !addr_i[2]) begin
         epol_d = addr_i[0];
         eie_d  = addr_i[1];
      end
      if (rd_en && ctl_sel && addr_i[0]) begin
         eflag_d = 1'b0;
      end
      if (ed_hit) begin
         eflag_d = 1'b1;
      end

      if (wr_en && !ctl_sel) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            if (32'(port_idx) == k) begin
               if (addr_i[0]) begin
                  ddr_d[k*PORT_WIDTH +: PORT_WIDTH] = di_i[PORT_WIDTH-1:0];
               end else begin
                  po_d[k*PORT_WIDTH +: PORT_WIDTH] = di_i[PORT_WIDTH-1:0];
               end
            end
         end
      end

      irq_d = (tflag_d & tie_d) | (eflag_d & eie_d);
   end

   // State registers; reset overrides any coincident bus access or event.
   always_ff @(posedge phi2_i) begin
      prev_q <= ed_pin;
      if (rst_i) begin
         po_q    <= '0;
         ddr_q   <= '0;
         timer_q <= 8'hFF;
         presc_q <= 10'd1023;
         sel_q   <= 2'b11;
         fast_q  <= 1'b0;
         tflag_q <= 1'b0;
         tie_q   <= 1'b0;
         eflag_q <= 1'b0;
         eie_q   <= 1'b0;
         epol_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         po_q    <= po_d;
         ddr_q   <= ddr_d;
         timer_q <= timer_d;
         presc_q <= presc_d;
         sel_q   <= sel_d;
         fast_q  <= fast_d;
         tflag_q <= tflag_d;
         tie_q   <= tie_d;
         eflag_q <= eflag_d;
         eie_q   <= eie_d;
         epol_q  <= epol_d;
         irq_q   <= irq_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riot_port_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riot_port_timer                                           |
// | Description : Self-checking bench for riot_port_timer: vector table,       |
// |               hand-written timer/edge/reset sequences, random traffic      |
// |               against a behavioural model.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_riot_port_timer;
   localparam int NP = 2;
   localparam int PW = 8;
   localparam int ED = 7;
`ifdef RIOT_PB7_IRQ_EN
   localparam logic [15:0] PB7M = 16'h8000;
`else
   localparam logic [15:0] PB7M = 16'h0000;
`endif

   logic        phi2 = 1'b0;
   logic        rst, cs, we_n, oe, irq;
   logic [4:0]  addr;
   logic [7:0]  di, dout;
   logic [15:0] pi, po, ddr;

   always #5 phi2 = ~phi2;

   riot_port_timer #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .ED_BIT(ED)) dut (
      .phi2_i(phi2), .rst_i(rst), .cs_i(cs), .we_n_i(we_n), .addr_i(addr),
      .di_i(di), .do_o(dout), .oe_o(oe), .pi_i(pi), .po_o(po), .ddr_o(ddr), .irq_o(irq)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: the timer value is a closed-form function of edges since load.
   bit          m_valid = 1'b0;
   int          m_n, m_V, m_D;
   bit          m_tflag, m_tie, m_eflag, m_eie, m_epol, m_prev, m_irq;
   logic [15:0] m_po, m_ddr;

   function automatic int m_timer();
      int u;
      u = (m_V + 1) * m_D;
      if (m_n < u) return m_V - m_n / m_D;
      return 255 - ((m_n - u) % 256);
   endfunction

   function automatic logic [15:0] m_po_eff();
      return m_po & ~PB7M;
   endfunction

   function automatic logic [15:0] m_ddr_eff();
      return (m_ddr & ~PB7M) | (m_irq ? PB7M : 16'h0000);
   endfunction

   function automatic logic [7:0] m_do(input bit c, input bit w, input logic [4:0] a,
                                       input logic [15:0] p);
      logic [15:0] pv;
      int idx;
      if (!c) return 8'h00;
      if (a[4]) return a[0] ? {m_tflag, m_eflag, 6'b000000} : 8'(m_timer());
      idx = int'(a[3:1]);
      if (idx >= NP) return 8'h00;
      pv = a[0] ? m_ddr_eff() : ((m_ddr_eff() & m_po_eff()) | (~m_ddr_eff() & p));
      return pv[idx*8 +: 8];
   endfunction

   task automatic m_edge(input bit r, input bit c, input bit w, input logic [4:0] a,
                         input logic [7:0] d, input logic [15:0] p);
      bit rd, wr, uf, edg;
      int nn, u, idx;
      if (r) begin
         m_po = '0; m_ddr = '0; m_V = 255; m_D = 1024; m_n = 0;
         m_tflag = 0; m_tie = 0; m_eflag = 0; m_eie = 0; m_epol = 0;
         m_prev = p[ED]; m_irq = 0; m_valid = 1;
         return;
      end
      rd  = c && w;
      wr  = c && !w;
      edg = m_epol ? (!m_prev && p[ED]) : (m_prev && !p[ED]);
      u   = (m_V + 1) * m_D;
      nn  = m_n + 1;
      uf  = (nn >= u) && (((nn - u) % 256) == 0);
      m_n = nn;
      if (rd && a[4] && !a[0]) begin m_tflag = 0; m_tie = a[3]; end
      if (uf) m_tflag = 1;
      if (wr && a[4] && a[2]) begin
         m_V = int'(d);
         case (a[1:0])
            2'd0: m_D = 1;
            2'd1: m_D = 8;
            2'd2: m_D = 64;
            default: m_D = 1024;
         endcase
         m_n = 0; m_tie = a[3]; m_tflag = 0;
      end
      if (wr && a[4] && !a[2]) begin m_epol = a[0]; m_eie = a[1]; end
      if (rd && a[4] && a[0]) m_eflag = 0;
      if (edg) m_eflag = 1;
      m_prev = p[ED];
      idx = int'(a[3:1]);
      if (wr && !a[4] && idx < NP) begin
         if (a[0]) m_ddr[idx*8 +: 8] = d;
         else      m_po[idx*8 +: 8]  = d;
      end
      m_irq = (m_tflag && m_tie) || (m_eflag && m_eie);
   endtask

   // One bus cycle: drive, compare combinational outputs, clock, compare registers.
   task automatic cyc(input bit r, input bit c, input bit w, input logic [4:0] a,
                      input logic [7:0] d, input logic [15:0] p, output logic [7:0] do_pre);
      rst = r; cs = c; we_n = w; addr = a; di = d; pi = p;
      #1;
      do_pre = dout;
      if (m_valid) begin
         chk("do_model", {24'h0, dout}, {24'h0, m_do(c, w, a, p)});
         chk("oe_model", {31'h0, oe}, {31'h0, c & w});
      end
      m_edge(r, c, w, a, d, p);
      @(posedge phi2);
      #1;
      if (m_valid) begin
         chk("po_model",  {16'h0, po},  {16'h0, m_po_eff()});
         chk("ddr_model", {16'h0, ddr}, {16'h0, m_ddr_eff()});
         chk("irq_model", {31'h0, irq}, {31'h0, m_irq});
      end
   endtask

   // Observe read data without letting the access reach a clock edge.
   task automatic peek(input logic [4:0] a, output logic [7:0] v);
      cs = 1'b1; we_n = 1'b1; addr = a;
      #1;
      v = dout;
      chk("peek_model", {24'h0, dout}, {24'h0, m_do(1'b1, 1'b1, a, pi)});
      cs = 1'b0;
   endtask

   task automatic idle(input int n);
      logic [7:0] dmy;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, dmy);
   endtask

   task automatic wait_timer_zero();
      logic [7:0] v;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         peek(5'h10, v);
         if (v == 8'h00) begin found = 1'b1; break; end
         idle(1);
      end
      chk("wait_timer_zero", {31'h0, found}, 32'h1);
   endtask

   typedef struct {
      bit          rst;
      bit          cs;
      bit          we_n;
      logic [4:0]  addr;
      logic [7:0]  di;
      logic [15:0] pi;
      bit          chk_do;
      logic [7:0]  exp_do;
      logic [15:0] exp_po;
      logic [15:0] exp_ddr;
      bit          exp_irq;
   } vec_t;

   vec_t vecs[20];

   initial begin
      logic [7:0]  v, dpre;
      logic [4:0]  ra;
      logic [7:0]  rd8;
      logic [15:0] rp;
      bit          rr, rc, rw;

      vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, 1'b1, 8'h00, 16'h0000, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'h01, 8'h0F, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h000F, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'h00, 8'hA5, 16'h0000, 1'b0, 8'h00, 16'h00A5, 16'h000F, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'h00, 8'h00, 16'h003C, 1'b1, 8'h35, 16'h00A5, 16'h000F, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'h01, 8'h00, 16'h003C, 1'b1, 8'h0F, 16'h00A5, 16'h000F, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'h03, 8'hFF, 16'h0000, 1'b0, 8'h00, 16'h00A5, 16'hFF0F, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'h02, 8'h5A, 16'h0000, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'h02, 8'h00, 16'h0000, 1'b1, 8'h5A, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'h0B, 8'hFF, 16'h0000, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'h0A, 8'h00, 16'h0000, 1'b1, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 5'h02, 8'h00, 16'h0000, 1'b1, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 5'h13, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0080, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 5'h11, 8'h00, 16'h0080, 1'b1, 8'h40, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 5'h11, 8'h00, 16'h0080, 1'b1, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 5'h12, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0080, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h5AA5, 16'hFF0F, 1'b1};
      vecs[19] = '{1'b1, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0};

      for (int i = 0; i < 20; i++) begin
         cyc(vecs[i].rst, vecs[i].cs, vecs[i].we_n, vecs[i].addr, vecs[i].di, vecs[i].pi, dpre);
         if (vecs[i].chk_do) chk($sformatf("vec%0d_do", i), {24'h0, dpre}, {24'h0, vecs[i].exp_do});
         chk($sformatf("vec%0d_po", i),  {16'h0, po & ~PB7M},  {16'h0, vecs[i].exp_po & ~PB7M});
         chk($sformatf("vec%0d_ddr", i), {16'h0, ddr & ~PB7M}, {16'h0, vecs[i].exp_ddr & ~PB7M});
         chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      end

      // Timer /8 from 2 with interrupt enabled, then fast mode after underflow.
      cyc(1'b0, 1'b1, 1'b0, 5'h1D, 8'h02, 16'h0000, dpre);
      idle(7);  peek(5'h10, v); chk("tmr_7cyc", {24'h0, v}, 32'h02);
      idle(1);  peek(5'h10, v); chk("tmr_8cyc", {24'h0, v}, 32'h01);
      idle(8);  peek(5'h10, v); chk("tmr_16cyc", {24'h0, v}, 32'h00);
      idle(7);  chk("irq_23cyc", {31'h0, irq}, 32'h0);
      idle(1);  chk("irq_24cyc", {31'h0, irq}, 32'h1);
      peek(5'h10, v); chk("tmr_wrap", {24'h0, v}, 32'hFF);
      peek(5'h11, v); chk("flags_uf", {24'h0, v}, 32'h80);
      idle(1);  peek(5'h10, v); chk("tmr_fast1", {24'h0, v}, 32'hFE);
      idle(1);  peek(5'h10, v); chk("tmr_fast2", {24'h0, v}, 32'hFD);
      cyc(1'b0, 1'b1, 1'b1, 5'h18, 8'h00, 16'h0000, dpre);
      chk("irq_after_read", {31'h0, irq}, 32'h0);
      peek(5'h10, v); chk("tmr_fast_persist", {24'h0, v}, 32'hFC);

      // Timer read coincident with a fast-mode wrap: set wins.
      wait_timer_zero();
      cyc(1'b0, 1'b1, 1'b1, 5'h18, 8'h00, 16'h0000, dpre);
      chk("irq_read_vs_uf", {31'h0, irq}, 32'h1);
      peek(5'h11, v); chk("flags_read_vs_uf", {24'h0, v}, 32'h80);

      // Timer load coincident with a wrap: load wins.
      wait_timer_zero();
      cyc(1'b0, 1'b1, 1'b0, 5'h1C, 8'h05, 16'h0000, dpre);
      chk("irq_load_vs_uf", {31'h0, irq}, 32'h0);
      peek(5'h10, v); chk("tmr_after_load", {24'h0, v}, 32'h05);
      peek(5'h11, v); chk("flags_load_vs_uf", {24'h0, v}, 32'h00);

      // Reset in the middle of a count with irq asserted.
      cyc(1'b0, 1'b1, 1'b0, 5'h01, 8'hFF, 16'h0000, dpre);
      cyc(1'b0, 1'b1, 1'b0, 5'h00, 8'h12, 16'h0000, dpre);
      chk("po_before_rst", {16'h0, po}, 32'h0012);
      idle(3);  chk("irq_div1_pre", {31'h0, irq}, 32'h0);
      idle(1);  chk("irq_div1_uf", {31'h0, irq}, 32'h1);
      cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00, 16'h0000, dpre);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_po", {16'h0, po}, 32'h0);
      chk("rst_ddr", {16'h0, ddr}, 32'h0);
      peek(5'h10, v); chk("rst_timer", {24'h0, v}, 32'hFF);

`ifdef RIOT_PB7_IRQ_EN
      cyc(1'b0, 1'b1, 1'b0, 5'h03, 8'hFF, 16'h0000, dpre);
      chk("pb7_ddr_idle", {16'h0, ddr}, 32'h7F00);
      cyc(1'b0, 1'b1, 1'b0, 5'h1C, 8'h00, 16'h0000, dpre);
      idle(1);
      chk("pb7_ddr_irq", {31'h0, ddr[15]}, 32'h1);
      cyc(1'b0, 1'b1, 1'b0, 5'h02, 8'hFF, 16'h0000, dpre);
      chk("pb7_po_forced", {31'h0, po[15]}, 32'h0);
      cyc(1'b0, 1'b1, 1'b1, 5'h10, 8'h00, 16'h0000, dpre);
      chk("pb7_ddr_clear", {31'h0, ddr[15]}, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 5'h03, 8'hFF, 16'h0000, dpre);
      chk("pb7_ddr_write", {31'h0, ddr[15]}, 32'h0);
`endif

      // Random traffic against the model.
      rp = 16'h0000;
      for (int i = 0; i < 1500; i++) begin
         rr  = ($urandom_range(0, 149) == 0);
         rc  = ($urandom_range(0, 3) != 0);
         rw  = 1'($urandom_range(0, 1));
         ra  = 5'($urandom);
         rd8 = 8'($urandom);
         if (ra[4] && ra[2] && !rw) begin
            rd8   = 8'($urandom_range(0, 20));
            ra[1] = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) rp = 16'($urandom);
         cyc(rr, rc, rw, ra, rd8, rp, dpre);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
